// File: rtl/rpn_stack_sequencer_if.sv
// Command, stack RAM, operand-load and status signals between the RPN sequencer and its neighbours.
// slave is the sequencer side; master is the front end plus datapath side.
interface rpn_stack_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              b_en;
    logic              a_en;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_result;
    logic [ADDR_W:0]   sp;
    logic [DATA_W-1:0] top;
    logic              done;
    logic              err_overflow;
    logic              err_underflow;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, mem_rdata, alu_result,
        output cmd_ready, mem_addr, mem_wren, mem_wdata, b_en, a_en, alu_op,
               sp, top, done, err_overflow, err_underflow
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, mem_rdata, alu_result,
        input  cmd_ready, mem_addr, mem_wren, mem_wdata, b_en, a_en, alu_op,
               sp, top, done, err_overflow, err_underflow
    );
endinterface

// File: rtl/rpn_stack_sequencer.sv
// Command sequencer for the RPN stack datapath: owns sp, drives stack RAM, A/B loads and ALU op.
// Latency 1-6 cycles per command (done pulses on return to IDLE); cmd_ready is low while busy, no queueing.
module rpn_stack_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    rpn_stack_sequencer_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE, WR, RD_B, RD_A, LD_A, EXEC, WB, RD_TOP, LD_TOP
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_SP = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] SP_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] SP_TWO   = (ADDR_W+1)'(2);

    state_t            state;
    logic              accept;
    logic              is_push, is_pop, is_clear, is_bin;
    logic [ADDR_W:0]   sp_dec;
    logic [ADDR_W-1:0] addr_m1, addr_m2;

    assign bus.cmd_ready = (state == IDLE);
    assign accept        = bus.cmd_valid && (state == IDLE);

    assign is_push  = (bus.cmd_op == 4'b0000);
    assign is_pop   = (bus.cmd_op == 4'b0001);
    assign is_clear = (bus.cmd_op == 4'b0010);
    assign is_bin   = bus.cmd_op[3];

    assign sp_dec  = bus.sp - SP_ONE;
    assign addr_m1 = ADDR_W'(bus.sp - SP_ONE);
    assign addr_m2 = ADDR_W'(bus.sp - SP_TWO);

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            bus.sp            <= '0;
            bus.top           <= DATA_W'(0);
            bus.mem_addr      <= '0;
            bus.mem_wren      <= 1'b0;
            bus.mem_wdata     <= DATA_W'(0);
            bus.a_en          <= 1'b0;
            bus.b_en          <= 1'b0;
            bus.alu_op        <= 3'b000;
            bus.done          <= 1'b0;
            bus.err_overflow  <= 1'b0;
            bus.err_underflow <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_push) begin
                            if (bus.sp == DEPTH_SP) begin
                                bus.err_overflow <= 1'b1;
                                bus.done         <= 1'b1;
                            end else begin
                                state         <= WR;
                                bus.mem_addr  <= bus.sp[ADDR_W-1:0];
                                bus.mem_wdata <= bus.cmd_data;
                                bus.mem_wren  <= 1'b1;
                            end
                        end else if (is_pop) begin
                            if (bus.sp == '0) begin
                                bus.err_underflow <= 1'b1;
                                bus.done          <= 1'b1;
                            end else if (bus.sp == SP_ONE) begin
                                bus.sp   <= '0;
                                bus.top  <= DATA_W'(0);
                                bus.done <= 1'b1;
                            end else begin
                                // new top lives one below the current top
                                state        <= RD_TOP;
                                bus.mem_addr <= addr_m2;
                            end
                        end else if (is_clear) begin
                            bus.sp            <= '0;
                            bus.top           <= DATA_W'(0);
                            bus.err_overflow  <= 1'b0;
                            bus.err_underflow <= 1'b0;
                            bus.done          <= 1'b1;
                        end else if (is_bin) begin
                            if (bus.sp < SP_TWO) begin
                                bus.err_underflow <= 1'b1;
                                bus.done          <= 1'b1;
                            end else begin
                                state        <= RD_B;
                                bus.alu_op   <= bus.cmd_op[2:0];
                                bus.mem_addr <= addr_m1;
                            end
                        end else begin
                            bus.done <= 1'b1;
                        end
                    end
                end
                WR: begin
                    bus.mem_wren <= 1'b0;
                    bus.sp       <= bus.sp + SP_ONE;
                    bus.top      <= bus.mem_wdata;
                    bus.done     <= 1'b1;
                    state        <= IDLE;
                end
                RD_B: begin
                    bus.mem_addr <= addr_m2;
                    bus.b_en     <= 1'b1;
                    state        <= RD_A;
                end
                RD_A: begin
                    bus.b_en <= 1'b0;
                    bus.a_en <= 1'b1;
                    state    <= LD_A;
                end
                LD_A: begin
                    bus.a_en <= 1'b0;
                    state    <= EXEC;
                end
                EXEC: begin
                    // result overwrites A's slot, which becomes the new top
                    bus.mem_wdata <= bus.alu_result;
                    bus.mem_wren  <= 1'b1;
                    state         <= WB;
                end
                WB: begin
                    bus.mem_wren <= 1'b0;
                    bus.sp       <= sp_dec;
                    bus.top      <= bus.mem_wdata;
                    bus.done     <= 1'b1;
                    state        <= IDLE;
                end
                RD_TOP: begin
                    state <= LD_TOP;
                end
                LD_TOP: begin
                    bus.top  <= bus.mem_rdata;
                    bus.sp   <= sp_dec;
                    bus.done <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_stack_sequencer.sv
// Bench for rpn_stack_sequencer (DEPTH=4): directed vector table, multi-cycle corner sequences,
// and randomized commands against a queue-based stack model, with a registered-read RAM and A/B/ALU.
module tb_rpn_stack_sequencer;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rpn_stack_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    rpn_stack_sequencer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a;
            3'd6:    return b;
            default: return ~(a & b);
        endcase
    endfunction

    // Datapath model: RAM with registered address, A/B operand registers, combinational ALU
    logic [7:0] ram [0:255];
    logic [7:0] addr_q, a_reg, b_reg;
    always @(posedge clk) begin
        if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wdata;
        addr_q <= bus.mem_addr;
        if (bus.b_en) b_reg <= bus.mem_rdata;
        if (bus.a_en) a_reg <= bus.mem_rdata;
    end
    assign bus.mem_rdata  = ram[addr_q];
    assign bus.alu_result = alu_f(bus.alu_op, a_reg, b_reg);

    int n_a = 0, n_b = 0, n_wr = 0, n_bad = 0;
    always @(negedge clk) begin
        if (bus.a_en) n_a++;
        if (bus.b_en) n_b++;
        if (bus.mem_wren) n_wr++;
        if (int'(bus.mem_addr) >= DEPTH || (bus.a_en && bus.b_en)) n_bad++;
    end

    int errors = 0, checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'h0;
        bus.cmd_data  = 8'h00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Issue one command; lat = cycles from accept edge to the done cycle, a1 = mem_addr one cycle after accept
    task automatic send(input logic [3:0] op, input logic [7:0] d, output int lat, output logic [7:0] a1);
        int w;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        w = 0;
        while (!bus.cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            errors++;
            $display("FAIL cmd_ready_timeout: got 0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        lat = 0;
        a1  = 8'h00;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) a1 = bus.mem_addr;
        end while (!bus.done && lat < 40);
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] data;
        int         sp;
        logic [7:0] top;
        int         lat;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t       vecs [18];
    int         lat, wr0, a0, b0, idx, exp_lat, exp_wr, exp_ab;
    logic [7:0] a1, exp_top, va, vb, rd;
    logic [3:0] op;
    logic       rdy, m_ovf, m_unf;
    logic [7:0] stk [$];

    initial begin
        vecs[0]  = '{4'h0, 8'd5,  1, 8'd5,  2, 1'b0, 1'b0};
        vecs[1]  = '{4'h0, 8'd3,  2, 8'd3,  2, 1'b0, 1'b0};
        vecs[2]  = '{4'h8, 8'd0,  1, 8'd8,  6, 1'b0, 1'b0};
        vecs[3]  = '{4'h1, 8'd0,  0, 8'd0,  1, 1'b0, 1'b0};
        vecs[4]  = '{4'h8, 8'd0,  0, 8'd0,  1, 1'b0, 1'b1};
        vecs[5]  = '{4'h2, 8'd0,  0, 8'd0,  1, 1'b0, 1'b0};
        vecs[6]  = '{4'h0, 8'd1,  1, 8'd1,  2, 1'b0, 1'b0};
        vecs[7]  = '{4'h0, 8'd2,  2, 8'd2,  2, 1'b0, 1'b0};
        vecs[8]  = '{4'h0, 8'd3,  3, 8'd3,  2, 1'b0, 1'b0};
        vecs[9]  = '{4'h0, 8'd4,  4, 8'd4,  2, 1'b0, 1'b0};
        vecs[10] = '{4'h0, 8'd9,  4, 8'd4,  1, 1'b1, 1'b0};
        vecs[11] = '{4'h1, 8'd0,  3, 8'd3,  3, 1'b1, 1'b0};
        vecs[12] = '{4'h9, 8'd0,  2, 8'hFF, 6, 1'b1, 1'b0};
        vecs[13] = '{4'h5, 8'd0,  2, 8'hFF, 1, 1'b1, 1'b0};
        vecs[14] = '{4'hC, 8'd0,  1, 8'hFE, 6, 1'b1, 1'b0};
        vecs[15] = '{4'h8, 8'd0,  1, 8'hFE, 1, 1'b1, 1'b1};
        vecs[16] = '{4'h2, 8'd0,  0, 8'd0,  1, 1'b0, 1'b0};
        vecs[17] = '{4'h1, 8'd0,  0, 8'd0,  1, 1'b0, 1'b1};

        do_reset();
        @(negedge clk);
        check("rst_sp", bus.sp, 0);
        check("rst_top", bus.top, 0);
        check("rst_done", bus.done, 0);
        check("rst_ovf", bus.err_overflow, 0);
        check("rst_unf", bus.err_underflow, 0);
        check("rst_wren", bus.mem_wren, 0);
        check("rst_a_en", bus.a_en, 0);
        check("rst_b_en", bus.b_en, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_alu_op", bus.alu_op, 0);
        check("rst_ready", bus.cmd_ready, 1);

        for (int i = 0; i < 18; i++) begin
            send(vecs[i].op, vecs[i].data, lat, a1);
            check($sformatf("vec%0d_sp", i), bus.sp, vecs[i].sp);
            check($sformatf("vec%0d_top", i), bus.top, vecs[i].top);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_ovf", i), bus.err_overflow, vecs[i].ovf);
            check($sformatf("vec%0d_unf", i), bus.err_underflow, vecs[i].unf);
        end

        // PUSH 5, PUSH 3, add: result in addr0, one pulse each on a_en and b_en
        do_reset();
        a0 = n_a; b0 = n_b; wr0 = n_wr;
        send(4'h0, 8'd5, lat, a1);
        send(4'h0, 8'd3, lat, a1);
        send(4'h8, 8'd0, lat, a1);
        check("add_rd_b_addr", a1, 1);
        check("add_ram0", ram[0], 8);
        check("add_a_pulses", n_a - a0, 1);
        check("add_b_pulses", n_b - b0, 1);
        check("add_writes", n_wr - wr0, 3);
        @(negedge clk);
        check("add_done_pulse", bus.done, 0);

        // underflow on empty stack: no RAM write
        do_reset();
        wr0 = n_wr;
        send(4'h8, 8'd0, lat, a1);
        check("unf_flag", bus.err_underflow, 1);
        check("unf_writes", n_wr - wr0, 0);
        send(4'h2, 8'd0, lat, a1);
        check("unf_clear", bus.err_underflow, 0);

        // overflow at DEPTH leaves the top slot intact
        do_reset();
        for (int i = 1; i <= 4; i++) send(4'h0, 8'(i), lat, a1);
        wr0 = n_wr;
        send(4'h0, 8'd9, lat, a1);
        check("ovf_flag", bus.err_overflow, 1);
        check("ovf_sp", bus.sp, 4);
        check("ovf_writes", n_wr - wr0, 0);
        check("ovf_ram3", ram[3], 4);

        // POP reads the entry below the top
        do_reset();
        send(4'h0, 8'd7, lat, a1);
        send(4'h0, 8'd9, lat, a1);
        send(4'h1, 8'd0, lat, a1);
        check("pop_rd_addr", a1, 0);
        check("pop_lat", lat, 3);
        check("pop_sp", bus.sp, 1);
        check("pop_top", bus.top, 7);
        send(4'h1, 8'd0, lat, a1);
        check("pop1_sp", bus.sp, 0);
        check("pop1_top", bus.top, 0);

        // reset mid-op aborts without writing back
        do_reset();
        send(4'h0, 8'd2, lat, a1);
        send(4'h0, 8'd6, lat, a1);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 4'h8;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        wr0 = n_wr;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_wren", bus.mem_wren, 0);
        check("abort_a_en", bus.a_en, 0);
        check("abort_b_en", bus.b_en, 0);
        check("abort_sp", bus.sp, 0);
        check("abort_ready", bus.cmd_ready, 1);
        repeat (6) @(negedge clk);
        check("abort_writes", n_wr - wr0, 0);
        check("abort_ram0", ram[0], 2);

        // cmd_valid held high, data advanced only on accept
        do_reset();
        wr0 = n_wr;
        idx = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 4'h0;
        bus.cmd_data  = 8'd1;
        for (int c = 0; c < 40 && idx < 3; c++) begin
            rdy = bus.cmd_ready;
            @(posedge clk);
            if (rdy) begin
                idx++;
                #1;
                if (idx < 3) bus.cmd_data = 8'(idx + 1);
                else bus.cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("stream_accepts", idx, 3);
        check("stream_sp", bus.sp, 3);
        check("stream_top", bus.top, 3);
        check("stream_writes", n_wr - wr0, 3);
        check("stream_ram2", ram[2], 3);

        // randomized commands against the stack model
        do_reset();
        stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        for (int n = 0; n < 250; n++) begin
            idx = $urandom_range(0, 99);
            rd  = 8'($urandom);
            if (idx < 35)      op = 4'h0;
            else if (idx < 55) op = 4'h1;
            else if (idx < 60) op = 4'h2;
            else if (idx < 70) op = 4'($urandom_range(3, 7));
            else               op = 4'h8 | 4'($urandom_range(0, 7));
            exp_wr = 0;
            exp_ab = 0;
            exp_lat = 1;
            if (op == 4'h0) begin
                if (stk.size() == DEPTH) m_ovf = 1'b1;
                else begin stk.push_back(rd); exp_lat = 2; exp_wr = 1; end
            end else if (op == 4'h1) begin
                if (stk.size() == 0) m_unf = 1'b1;
                else begin
                    exp_lat = (stk.size() == 1) ? 1 : 3;
                    void'(stk.pop_back());
                end
            end else if (op == 4'h2) begin
                stk.delete();
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else if (op[3]) begin
                if (stk.size() < 2) m_unf = 1'b1;
                else begin
                    vb = stk.pop_back();
                    va = stk.pop_back();
                    stk.push_back(alu_f(op[2:0], va, vb));
                    exp_lat = 6; exp_wr = 1; exp_ab = 1;
                end
            end
            exp_top = (stk.size() > 0) ? stk[stk.size()-1] : 8'h00;
            wr0 = n_wr; a0 = n_a; b0 = n_b;
            send(op, rd, lat, a1);
            check($sformatf("rnd%0d_op%0h_sp", n, op), bus.sp, stk.size());
            check($sformatf("rnd%0d_op%0h_top", n, op), bus.top, exp_top);
            check($sformatf("rnd%0d_op%0h_lat", n, op), lat, exp_lat);
            check($sformatf("rnd%0d_op%0h_ovf", n, op), bus.err_overflow, m_ovf);
            check($sformatf("rnd%0d_op%0h_unf", n, op), bus.err_underflow, m_unf);
            check($sformatf("rnd%0d_op%0h_wr", n, op), n_wr - wr0, exp_wr);
            check($sformatf("rnd%0d_op%0h_a_en", n, op), n_a - a0, exp_ab);
            check($sformatf("rnd%0d_op%0h_b_en", n, op), n_b - b0, exp_ab);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int i = 0; i < stk.size(); i++) check($sformatf("rnd_ram%0d", i), ram[i], stk[i]);

        check("addr_range_and_enable_overlap", n_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
